serial_sub_w: RTL and testbench

- Parametrised multi-cycle subtractor; successor to the single-bit full subtractor cell.
- Computes diff = a - b - bin on WIDTH-bit operands, STEP bits per clock, LSB first.
- Uses a chain of STEP full-subtractor slices and a registered borrow.
- Start/busy/done handshake. Reports borrow-out and signed overflow; serves as the small-area arithmetic unit in datapaths that can tolerate latency.

---
 rtl/serial_sub_w.sv | 121 ++++++++++++
 tb/tb_serial_sub_w.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_w.sv
// Multi-cycle subtractor: diff = a - b - bin, STEP bits per clock, LSB first.
// Uses a ripple of STEP full-subtractor slices and a borrow register that is carried between steps.
module serial_sub_w #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [STEP:0]    br_c;
  logic [STEP-1:0]  d_c;
  logic [WIDTH-1:0] res_shift;
  logic             accept;

  always_comb begin
    br_c    = '0;
    d_c     = '0;
    br_c[0] = br_q;
    for (int i = 0; i < STEP; i++) begin
      d_c[i]    = a_sh_q[i] ^ b_sh_q[i] ^ br_c[i];
      br_c[i+1] = (~a_sh_q[i] & b_sh_q[i]) | (~(a_sh_q[i] ^ b_sh_q[i]) & br_c[i]);
    end
    // new difference bits enter at the MSB end; after N steps the word is aligned
    res_shift = WIDTH'({d_c, res_q} >> STEP);
  end

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      state_d = S_RUN;
      a_sh_d  = a;
      b_sh_d  = b;
      br_d    = bin;
      res_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          a_sh_d = a_sh_q >> STEP;
          b_sh_d = b_sh_q >> STEP;
          res_d  = res_shift;
          br_d   = br_c[STEP];
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = S_DONE;
            diff_d  = res_shift;
            bout_d  = br_c[STEP];
            // signed overflow: borrow into the sign bit differs from borrow out of it
            ovf_d   = br_c[STEP] ^ br_c[STEP-1];
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_sub_w.sv
// Bench for serial_sub_w: several width/step instances checked against an arithmetic model
// of a - b - bin, including latency, busy length, result holding, back-to-back and reset abort.
module tb_serial_sub_w;
  localparam int NI = 7;

  function automatic int cfg_w(int i);
    return (i < 4) ? 8 : 16;
  endfunction

  function automatic int cfg_s(int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      4: return 1;
      5: return 2;
      default: return 16;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [NI-1:0] start_a = '0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic        bin_bus = 1'b0;

  logic [15:0] diff_a [NI];
  logic [NI-1:0] busy_a, done_a, bout_a, ovf_a;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);
    logic [W-1:0] d;
    serial_sub_w #(.WIDTH(W), .STEP(S)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start_a[g]),
      .a    (a_bus[W-1:0]),
      .b    (b_bus[W-1:0]),
      .bin  (bin_bus),
      .busy (busy_a[g]),
      .done (done_a[g]),
      .diff (d),
      .bout (bout_a[g]),
      .ovf  (ovf_a[g])
    );
    assign diff_a[g] = 16'(d);
  end

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] prev_d  [NI];
  logic        prev_bo [NI];
  logic        prev_ov [NI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference: plain integer arithmetic on the operand values
  task automatic model(input int k, input logic [15:0] av, input logic [15:0] bv, input logic bn,
                       output logic [15:0] ed, output logic eb, output logic eo);
    longint w, m, ua, ub, sa, sb, r;
    w  = cfg_w(k);
    m  = longint'(1) << w;
    ua = longint'(av) % m;
    ub = longint'(bv) % m;
    r  = ua - ub - longint'(bn);
    ed = 16'((r + m) % m);
    eb = (ua < ub + longint'(bn));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = sa - sb - longint'(bn);
    eo = (r < -(m / 2)) || (r > m / 2 - 1);
  endtask

  function automatic logic [15:0] msk(int k, logic [15:0] v);
    return (cfg_w(k) == 16) ? v : (v & 16'h00FF);
  endfunction

  // waits for done after the accepting edge; returns the cycle count or -1
  task automatic wait_done(input int k, input int limit, input bit noisy, output int got);
    got = -1;
    for (int j = 1; j <= limit; j++) begin
      @(posedge clk); #1;
      if (done_a[k]) begin
        got = j;
        break;
      end
      chk("busy_run", 32'(busy_a[k]), 32'd1);
      chk("diff_held", 32'(diff_a[k]), 32'(prev_d[k]));
      if (noisy) begin
        start_a[k] = 1'($urandom);
        a_bus = 16'($urandom);
        b_bus = 16'($urandom);
        bin_bus = 1'($urandom);
      end
    end
  endtask

  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic bn, input bit noisy);
    logic [15:0] ed;
    logic eb, eo;
    int n, got;
    n = cfg_w(k) / cfg_s(k);
    model(k, av, bv, bn, ed, eb, eo);
    @(negedge clk);
    a_bus = av; b_bus = bv; bin_bus = bn; start_a[k] = 1'b1;
    @(posedge clk); #1;
    start_a[k] = 1'b0;
    if (noisy) begin
      a_bus = 16'($urandom); b_bus = 16'($urandom); bin_bus = 1'($urandom);
    end
    chk("busy_first", 32'(busy_a[k]), 32'd1);
    wait_done(k, n + 3, noisy, got);
    start_a[k] = 1'b0;
    chk("latency", 32'(got), 32'(n));
    chk("busy_at_done", 32'(busy_a[k]), 32'd0);
    chk("diff", 32'(diff_a[k]), 32'(ed));
    chk("bout", 32'(bout_a[k]), 32'(eb));
    chk("ovf", 32'(ovf_a[k]), 32'(eo));
    prev_d[k] = ed; prev_bo[k] = eb; prev_ov[k] = eo;
    @(posedge clk); #1;
    chk("done_pulse", 32'(done_a[k]), 32'd0);
  endtask

  initial begin
    int got, k;
    logic [15:0] ed, av, bv;
    logic eb, eo, bn;
    for (int i = 0; i < NI; i++) begin
      prev_d[i] = '0; prev_bo[i] = 1'b0; prev_ov[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", 32'(busy_a[i]), 32'd0);
      chk("rst_done", 32'(done_a[i]), 32'd0);
      chk("rst_diff", 32'(diff_a[i]), 32'd0);
      chk("rst_bout", 32'({bout_a[i], ovf_a[i]}), 32'd0);
    end

    // directed vectors
    run_op(0, 16'h005A, 16'h003C, 1'b0, 1'b0);
    chk("t1_diff", 32'(diff_a[0]), 32'h1E);
    run_op(0, 16'h0000, 16'h0001, 1'b0, 1'b0);
    chk("t2a", 32'({diff_a[0], bout_a[0], ovf_a[0]}), 32'({16'hFF, 1'b1, 1'b0}));
    run_op(0, 16'h0080, 16'h0001, 1'b0, 1'b0);
    chk("t2b", 32'({diff_a[0], bout_a[0], ovf_a[0]}), 32'({16'h7F, 1'b0, 1'b1}));
    run_op(0, 16'h0010, 16'h0010, 1'b1, 1'b0);
    chk("t2c", 32'({diff_a[0], bout_a[0], ovf_a[0]}), 32'({16'hFF, 1'b1, 1'b0}));
    run_op(2, 16'h00C3, 16'h0045, 1'b0, 1'b0);
    chk("t3", 32'({diff_a[2], bout_a[2], ovf_a[2]}), 32'({16'h7E, 1'b0, 1'b1}));
    run_op(0, 16'h00A7, 16'h0033, 1'b1, 1'b1);

    // back-to-back with start held high
    @(negedge clk);
    a_bus = 16'h0033; b_bus = 16'h0044; bin_bus = 1'b0; start_a[0] = 1'b1;
    model(0, 16'h0033, 16'h0044, 1'b0, ed, eb, eo);
    @(posedge clk); #1;
    a_bus = 16'h00EE;
    wait_done(0, 11, 1'b0, got);
    chk("b2b_lat1", 32'(got), 32'd8);
    chk("b2b_diff1", 32'({diff_a[0], bout_a[0], ovf_a[0]}), 32'({ed, eb, eo}));
    prev_d[0] = ed; prev_bo[0] = eb; prev_ov[0] = eo;
    a_bus = 16'h0090; b_bus = 16'h0020; bin_bus = 1'b1;
    model(0, 16'h0090, 16'h0020, 1'b1, ed, eb, eo);
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    a_bus = 16'h0001;
    chk("b2b_busy", 32'(busy_a[0]), 32'd1);
    wait_done(0, 11, 1'b0, got);
    chk("b2b_lat2", 32'(got + 1), 32'd9);
    chk("b2b_diff2", 32'({diff_a[0], bout_a[0], ovf_a[0]}), 32'({ed, eb, eo}));
    prev_d[0] = ed; prev_bo[0] = eb; prev_ov[0] = eo;
    @(posedge clk); #1;

    // reset during RUN aborts the operation
    @(negedge clk);
    a_bus = 16'h0012; b_bus = 16'h0034; bin_bus = 1'b0; start_a[0] = 1'b1;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", 32'({busy_a[0], done_a[0], bout_a[0], ovf_a[0]}), 32'd0);
    chk("abort_diff", 32'(diff_a[0]), 32'd0);
    for (int i = 0; i < NI; i++) begin
      prev_d[i] = '0; prev_bo[i] = 1'b0; prev_ov[i] = 1'b0;
    end
    got = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      got += done_a[0];
    end
    chk("abort_no_done", 32'(got), 32'd0);
    run_op(0, 16'h0012, 16'h0034, 1'b0, 1'b0);

    // randomized over STEP in {1,2,WIDTH} plus the STEP=4 instance
    for (int t = 0; t < 1000; t++) begin
      k  = int'($urandom_range(0, NI - 1));
      av = msk(k, 16'($urandom));
      bv = msk(k, 16'($urandom));
      bn = 1'($urandom);
      if ((t % 8) == 0) bv = av;
      run_op(k, av, bv, bn, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
